gate_test_sequencer: RTL and testbench
======================================

Name: gate_test_sequencer

Overview:
- Self-test controller for a 2-input single-bit logic cell (e.g. the AND cell).
- Drives the cell's two inputs through all four combinations in order 00, 01, 10, 11, given as {a,b}.
- After a programmable settle time it samples the cell output and compares it against a parameterised truth table.
- Reports done, pass/fail, error count and the first failing vector. Sits beside the cell under test in bring-up and self-test builds.

Parameters:
- TRUTH, 4'b1000: expected output per vector; bit index = {a,b}. The default encodes AND.
- SETTLE_CYCLES, 2: clock cycles between applying a vector and sampling dut_out. Legal range is 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a test run; accepted only in IDLE or DONE.
- abort  input  1  cancel a run in progress.
- dut_out  input  1  output of the cell under test.
- dut_a  output  1  registered input a to the cell.
- dut_b  output  1  registered input b to the cell.
- busy  output  1  high in APPLY, SETTLE and CHECK.
- done  output  1  high in DONE; held until the next start, abort or rst.
- pass  output  1  meaningful only while done=1: 1 when err_count==0.
- err_count  output  3  number of mismatching vectors, 0..4.
- fail_valid  output  1  set on the first mismatch of a run.
- fail_vec  output  2  {a,b} of the first mismatch; valid when fail_valid=1.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. The clock port is clk and the reset port is rst.
- Reset values:
  - State is IDLE and the vector index is 0.
  - dut_a, dut_b, busy, done, pass, fail_valid are 0.
  - err_count and fail_vec are 0.
  - Settle counter is 0.
  - rst overrides every other input in every state, including mid-run.
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE or DONE:
  - start=1 and abort=0: clear err_count, fail_valid, fail_vec, done and pass; set idx=0; go to APPLY.
  - start and abort both 1: abort wins and start is ignored. From DONE this returns to IDLE.
- APPLY:
  - Register dut_a=idx[1] and dut_b=idx[0].
  - Load the settle counter with SETTLE_CYCLES-1.
  - Go to SETTLE.
- SETTLE:
  - Counter is nonzero: decrement it and stay.
  - Counter is zero: go to CHECK. SETTLE always lasts exactly SETTLE_CYCLES cycles.
- CHECK:
  - Sample dut_out on this edge.
  - Mismatch (dut_out != TRUTH[idx]): increment err_count. If fail_valid=0, load fail_vec=idx and set fail_valid=1.
  - idx==3: go to DONE.
  - Otherwise: increment idx and go to APPLY.
- DONE:
  - done=1 and pass=(err_count==0).
  - dut_a and dut_b hold the last vector, 11.
- Latency: each vector takes SETTLE_CYCLES+2 cycles. done rises 4*(SETTLE_CYCLES+2) edges after the edge that accepted start; this is 16 for the default.
- abort=1 in APPLY, SETTLE or CHECK:
  - Next edge goes to IDLE with dut_a=dut_b=0, busy=0, done=0.
  - err_count, fail_valid and fail_vec are left frozen; they are don't-care after an abort.
- start while busy=1 is ignored with no effect.
- dut_a and dut_b change only on the APPLY edge, on abort and on rst.
- err_count cannot exceed 4 and needs no saturation logic.
- idx is 2 bits. The transition 3 to DONE never wraps idx back to 0 inside a run.

Test Plan:
- AND cell, defaults, start pulse at cycle 0:
  - dut_{a,b} steps 00, 01, 10, 11, each held 4 cycles.
  - done=1 at edge 16, pass=1, err_count=0, fail_valid=0, busy=0 in DONE.
- OR cell with TRUTH=4'b1000:
  - Mismatches at 01 and 10, giving err_count=2, fail_vec=01, fail_valid=1, pass=0 at done.
- Cell stuck at 0, SETTLE_CYCLES=1:
  - done at edge 12, err_count=1, fail_vec=11, pass=0.
- abort asserted at cycle 6 (vector 01 in SETTLE):
  - IDLE at cycle 7, dut_a=dut_b=0, busy=0, done=0.
  - A new start then gives a clean pass at +16 edges.
- start re-pulsed at cycle 5 of a run: ignored, done still at edge 16. start pulsed in DONE: done drops next edge, err_count clears, run repeats.
- rst held for one cycle at cycle 9: next edge all outputs are 0 and state is IDLE; later start completes normally.

Source files
------------

// File: rtl/gate_test_sequencer.sv
// Self-test sequencer for a 2-input single-bit cell: walks {a,b} through 00..11,
// waits a settle time, samples the cell output and checks it against a truth table.
module gate_test_sequencer #(
  parameter logic [3:0]  TRUTH         = 4'b1000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] fail_vec
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dut_a_q, dut_a_d;
  logic       dut_b_q, dut_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic       fail_valid_q, fail_valid_d;
  logic [1:0] fail_vec_q, fail_vec_d;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    dut_a_d      = dut_a_q;
    dut_b_d      = dut_b_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;

    // Abort wins over start everywhere; error status is deliberately left as is.
    if (abort) begin
      state_d = S_IDLE;
      dut_a_d = 1'b0;
      dut_b_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d      = S_APPLY;
            idx_d        = 2'd0;
            err_d        = 3'd0;
            fail_valid_d = 1'b0;
            fail_vec_d   = 2'd0;
          end else begin
            state_d = state_q;
          end
        end
        S_APPLY: begin
          dut_a_d = idx_q[1];
          dut_b_d = idx_q[0];
          cnt_d   = SETTLE_LOAD;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (dut_out != TRUTH[idx_q]) begin
            err_d = err_q + 3'd1;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = idx_q;
            end else begin
              fail_valid_d = fail_valid_q;
            end
          end else begin
            err_d = err_q;
          end
          if (idx_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_APPLY;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == 3'd0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= 4'd0;
      dut_a_q      <= 1'b0;
      dut_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= 3'd0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      dut_a_q      <= dut_a_d;
      dut_b_q      <= dut_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign dut_a      = dut_a_q;
  assign dut_b      = dut_b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench: an AND cell, an OR cell checked against AND, and a stuck-at-0 cell
// with a one-cycle settle, all driven from shared start/abort/rst.
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  logic rst, start, abort;

  logic       a0, b0, busy0, done0, pass0, fv0;
  logic [2:0] err0;
  logic [1:0] fvec0;
  logic       a1, b1, busy1, done1, pass1, fv1;
  logic [2:0] err1;
  logic [1:0] fvec1;
  logic       a2, b2, busy2, done2, pass2, fv2;
  logic [2:0] err2;
  logic [1:0] fvec2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gate_test_sequencer u_and (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(a0 & b0),
    .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .fail_vec(fvec0));

  gate_test_sequencer #(.TRUTH(4'b1000)) u_or (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(a1 | b1),
    .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .fail_vec(fvec1));

  gate_test_sequencer #(.SETTLE_CYCLES(1)) u_stk (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(1'b0),
    .dut_a(a2), .dut_b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .fail_vec(fvec2));

  typedef struct {
    int         e;
    logic       a, b, busy, done, pass;
    logic [2:0] err;
    logic       fv;
    logic [1:0] fvec;
  } vec_t;

  vec_t tbl [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pulse start so it is accepted on the next edge (edge 0 of the run).
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Count edges after the start edge until the AND instance reports done.
  task automatic wait_done(input string nm, input int exp_e);
    int n;
    n = 0;
    while (done0 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(nm, n, exp_e);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;

    tbl[0] = '{0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    tbl[1] = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    tbl[2] = '{4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    tbl[3] = '{5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    tbl[4] = '{8,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    tbl[5] = '{9,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    tbl[6] = '{12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    tbl[7] = '{13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    tbl[8] = '{15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0};
    tbl[9] = '{16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 2'd0};

    step(); step();
    rst = 1'b0;
    chk("reset_and", {a0, b0, busy0, done0, pass0, err0, fv0, fvec0}, 32'd0);
    chk("reset_or",  {a1, b1, busy1, done1, pass1, err1, fv1, fvec1}, 32'd0);

    // Default AND run, checked against the per-edge table.
    kick();
    begin
      int k;
      k = 0;
      for (int e = 0; e <= 16; e++) begin
        if (e > 0) step();
        if (k < 10 && tbl[k].e == e) begin
          chk($sformatf("vec_e%0d", e),
              {a0, b0, busy0, done0, pass0, err0, fv0, fvec0},
              {tbl[k].a, tbl[k].b, tbl[k].busy, tbl[k].done, tbl[k].pass,
               tbl[k].err, tbl[k].fv, tbl[k].fvec});
          k++;
        end
        if (e == 11) chk("stuck_not_done_e11", done2, 1'b0);
        if (e == 12) chk("stuck_done_e12", {done2, pass2, err2, fv2, fvec2}, {1'b1, 1'b0, 3'd1, 1'b1, 2'd3});
      end
    end
    chk("or_result", {done1, pass1, err1, fv1, fvec1}, {1'b1, 1'b0, 3'd2, 1'b1, 2'd1});

    // Start in DONE restarts: done drops, status clears.
    kick();
    chk("restart_and", {busy0, done0, pass0}, {1'b1, 1'b0, 1'b0});
    chk("restart_or_clear", {done1, err1, fv1, fvec1}, 7'd0);
    // Start re-pulsed while busy must not disturb the run.
    for (int e = 1; e <= 4; e++) step();
    kick();
    begin
      int n;
      n = 5;
      while (done0 !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      chk("repulse_done_edge", n, 16);
    end
    chk("repulse_pass", {pass0, err0}, {1'b1, 3'd0});

    // Start and abort together in DONE: abort wins, back to IDLE.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort_over_start", {busy0, done0}, 2'b00);

    // Abort in SETTLE of vector 01.
    kick();
    for (int e = 1; e <= 5; e++) step();
    chk("pre_abort_vec01", {a0, b0, busy0}, 3'b011);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", {a0, b0, busy0, done0}, 4'b0000);
    kick();
    wait_done("after_abort_done_edge", 16);
    chk("after_abort_pass", {pass0, err0, fv0}, {1'b1, 3'd0, 1'b0});

    // Mid-run synchronous reset at edge 9.
    kick();
    for (int e = 1; e <= 8; e++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrun_rst_and", {a0, b0, busy0, done0, pass0, err0, fv0, fvec0}, 32'd0);
    chk("midrun_rst_or",  {a1, b1, busy1, done1, pass1, err1, fv1, fvec1}, 32'd0);
    step();
    chk("idle_after_rst", {busy0, done0}, 2'b00);
    kick();
    wait_done("after_rst_done_edge", 16);
    chk("after_rst_pass", {pass0, a0, b0, busy0}, 4'b1110);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
